mpq_max_priority_queue: RTL and testbench

Max-priority queue engine. It loads a byte stream into an internal array and executes queue commands on it: build heap, extract max, increase value, insert, and write-out. On the write command it dumps the array, in array order, to an external byte-wide RAM port and then signals completion. The block sits between a stream/command source and a simple write-only RAM.

---
 rtl/mpq_max_priority_queue_if.sv | 25 ++
 rtl/mpq_max_priority_queue.sv | 199 +++++++++++++++++++
 tb/tb_mpq_max_priority_queue.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mpq_max_priority_queue_if.sv
// Stream, command and RAM write port bundle for the max-priority queue engine.
// master = stream/command source plus RAM sink, slave = the queue engine.
interface mpq_max_priority_queue_if;
  logic       data_valid;
  logic [7:0] data;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [7:0] index;
  logic [7:0] value;
  logic       busy;
  logic       RAM_valid;
  logic [7:0] RAM_A;
  logic [7:0] RAM_D;
  logic       done;

  modport master (
    output data_valid, data, cmd_valid, cmd, index, value,
    input  busy, RAM_valid, RAM_A, RAM_D, done
  );

  modport slave (
    input  data_valid, data, cmd_valid, cmd, index, value,
    output busy, RAM_valid, RAM_A, RAM_D, done
  );
endinterface

// File: rtl/mpq_max_priority_queue.sv
// Max-priority queue engine: loads a byte stream into a register array, runs
// heap commands one compare/swap step per cycle and dumps the array to a RAM.
// CAP must stay below 128 so counts fit the 8-bit address/index space.
module mpq_max_priority_queue #(
  parameter int CAP = 32
) (
  input  logic clk,
  input  logic rst,
  mpq_max_priority_queue_if.slave bus
);
  localparam int AW = $clog2(CAP);
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] CAP_N = NW'(CAP);

  typedef enum logic [2:0] {
    S_IDLE, S_BUILD, S_HEAPIFY, S_SIFTUP, S_WRITE, S_DONE
  } state_t;

  state_t state_reg, state_next;

  // Multi-ported reads (node plus both children) keep this in registers.
  logic [7:0]    a_reg [CAP];
  logic [NW-1:0] n_reg;
  logic [AW-1:0] hi_reg;        // sift-down cursor
  logic [AW-1:0] bi_reg;        // build loop cursor
  logic [AW-1:0] si_reg;        // sift-up cursor
  logic          build_mode_reg;
  logic [NW-1:0] wk_reg;        // write-out cursor
  logic          ram_valid_reg;
  logic [7:0]    ram_a_reg;
  logic [7:0]    ram_d_reg;

  logic          busy_c;
  logic          done_c;
  logic          cmd_go;

  logic [AW:0]   l_idx;
  logic [AW+1:0] r_idx;
  logic          l_ok;
  logic          r_ok;
  logic [AW-1:0] lg0;
  logic [AW-1:0] lg;
  logic          heap_swap;
  logic [AW-1:0] par;
  logic          up_swap;
  logic [NW-1:0] n_m1;
  logic [AW-1:0] half_m1;

  assign cmd_go  = (state_reg == S_IDLE) && bus.cmd_valid && (bus.cmd <= 3'd4);
  assign n_m1    = n_reg - 1'b1;
  assign half_m1 = n_reg[NW-1:1] - 1'b1;

  // Sift-down step: pick the largest of node and existing children.
  always_comb begin
    l_idx     = {hi_reg, 1'b1};
    r_idx     = {1'b0, l_idx} + 1'b1;
    l_ok      = l_idx < n_reg;
    r_ok      = r_idx < {1'b0, n_reg};
    lg0       = (l_ok && (a_reg[l_idx[AW-1:0]] > a_reg[hi_reg])) ? l_idx[AW-1:0] : hi_reg;
    lg        = (r_ok && (a_reg[r_idx[AW-1:0]] > a_reg[lg0])) ? r_idx[AW-1:0] : lg0;
    heap_swap = (lg != hi_reg);
  end

  // Sift-up step: swap with the parent while the parent is strictly smaller.
  always_comb begin
    par     = (si_reg - 1'b1) >> 1;
    up_swap = (si_reg != '0) && (a_reg[par] < a_reg[si_reg]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (cmd_go) begin
          case (bus.cmd)
            3'd0:    state_next = S_BUILD;
            3'd1:    state_next = S_HEAPIFY;
            3'd4:    state_next = (n_reg == '0) ? S_DONE : S_WRITE;
            default: state_next = S_SIFTUP;
          endcase
        end
      end
      S_BUILD:   state_next = (n_reg[NW-1:1] == '0) ? S_IDLE : S_HEAPIFY;
      S_HEAPIFY: begin
        if (!heap_swap && !(build_mode_reg && bi_reg != '0)) state_next = S_IDLE;
      end
      S_SIFTUP:  state_next = up_swap ? S_SIFTUP : S_IDLE;
      S_WRITE:   state_next = (wk_reg == n_reg) ? S_DONE : S_WRITE;
      S_DONE:    state_next = S_DONE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy_c = (state_reg != S_IDLE);
    done_c = (state_reg == S_DONE);
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.RAM_valid = ram_valid_reg;
  assign bus.RAM_A     = ram_a_reg;
  assign bus.RAM_D     = ram_d_reg;

  // Datapath: loading, command setup, heap steps and registered RAM port.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg          <= '0;
      hi_reg         <= '0;
      bi_reg         <= '0;
      si_reg         <= '0;
      build_mode_reg <= 1'b0;
      wk_reg         <= '0;
      ram_valid_reg  <= 1'b0;
      ram_a_reg      <= '0;
      ram_d_reg      <= '0;
    end else begin
      ram_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (cmd_go) begin
            case (bus.cmd)
              3'd1: begin
                build_mode_reg <= 1'b0;
                hi_reg         <= '0;
                if (n_reg != '0) begin
                  a_reg[0] <= a_reg[n_m1[AW-1:0]];
                  n_reg    <= n_m1;
                end
              end
              3'd2: begin
                // Out-of-range index: sift-up from the root does nothing.
                if (bus.index < {{(8-NW){1'b0}}, n_reg}) begin
                  a_reg[bus.index[AW-1:0]] <= bus.value;
                  si_reg                   <= bus.index[AW-1:0];
                end else begin
                  si_reg <= '0;
                end
              end
              3'd3: begin
                if (n_reg < CAP_N) begin
                  a_reg[n_reg[AW-1:0]] <= bus.value;
                  n_reg                <= n_reg + 1'b1;
                  si_reg               <= n_reg[AW-1:0];
                end else begin
                  si_reg <= '0;
                end
              end
              3'd4:    wk_reg <= '0;
              default: ;
            endcase
          end else if (bus.data_valid && (n_reg < CAP_N)) begin
            a_reg[n_reg[AW-1:0]] <= bus.data;
            n_reg                <= n_reg + 1'b1;
          end
        end
        S_BUILD: begin
          build_mode_reg <= 1'b1;
          bi_reg         <= half_m1;
          hi_reg         <= half_m1;
        end
        S_HEAPIFY: begin
          if (heap_swap) begin
            a_reg[hi_reg] <= a_reg[lg];
            a_reg[lg]     <= a_reg[hi_reg];
            hi_reg        <= lg;
          end else if (build_mode_reg && bi_reg != '0) begin
            bi_reg <= bi_reg - 1'b1;
            hi_reg <= bi_reg - 1'b1;
          end
        end
        S_SIFTUP: begin
          if (up_swap) begin
            a_reg[par]    <= a_reg[si_reg];
            a_reg[si_reg] <= a_reg[par];
            si_reg        <= par;
          end
        end
        S_WRITE: begin
          if (wk_reg < n_reg) begin
            ram_valid_reg <= 1'b1;
            ram_a_reg     <= {{(8-NW){1'b0}}, wk_reg};
            ram_d_reg     <= a_reg[wk_reg[AW-1:0]];
            wk_reg        <= wk_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mpq_max_priority_queue.sv
// Directed bench for the max-priority queue engine with a behavioural heap
// model and a per-cycle compare process on the RAM write port.
module tb_mpq_max_priority_queue;
  localparam int CAP = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b0;

  mpq_max_priority_queue_if bus();

  mpq_max_priority_queue #(.CAP(CAP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural model state and the bench-side RAM image.
  int m[CAP];
  int mn = 0;
  bit m_done = 0;
  int wexp = 0;
  int ram[256];
  int load_q[$];
  int expq[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void m_heapify(input int start);
    int i, l, r, lg, t;
    i = start;
    while (1) begin
      l = 2 * i + 1;
      r = l + 1;
      lg = i;
      if (l < mn && m[l] > m[i]) lg = l;
      if (r < mn && m[r] > m[lg]) lg = r;
      if (lg == i) break;
      t = m[i]; m[i] = m[lg]; m[lg] = t;
      i = lg;
    end
  endfunction

  function automatic void m_siftup(input int start);
    int i, t;
    i = start;
    while (i > 0 && m[(i - 1) / 2] < m[i]) begin
      t = m[i]; m[i] = m[(i - 1) / 2]; m[(i - 1) / 2] = t;
      i = (i - 1) / 2;
    end
  endfunction

  function automatic void m_apply(input int c, input int idx, input int val);
    if (m_done) return;
    case (c)
      0: for (int i = mn / 2 - 1; i >= 0; i--) m_heapify(i);
      1: if (mn != 0) begin m[0] = m[mn - 1]; mn--; m_heapify(0); end
      2: if (idx < mn) begin m[idx] = val; m_siftup(idx); end
      3: if (mn < CAP) begin m[mn] = val; mn++; m_siftup(mn - 1); end
      4: begin wexp = 0; m_done = 1; end
      default: ;
    endcase
  endfunction

  always @(posedge clk) rst_q <= rst;

  // Compare process: reset values and every RAM write against the model.
  always @(negedge clk) begin
    if (rst_q) begin
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_ram_valid", int'(bus.RAM_valid), 0);
      chk("rst_ram_a", int'(bus.RAM_A), 0);
      chk("rst_ram_d", int'(bus.RAM_D), 0);
      chk("rst_done", int'(bus.done), 0);
    end else if (bus.RAM_valid) begin
      if (!m_done || wexp >= mn) begin
        chk("unexpected_write", 1, 0);
      end else begin
        chk("ram_addr", int'(bus.RAM_A), wexp);
        chk("ram_data", int'(bus.RAM_D), m[wexp]);
        $display("write addr=%0d data=%0d", bus.RAM_A, bus.RAM_D);
        wexp++;
      end
      ram[bus.RAM_A] = int'(bus.RAM_D);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.data_valid = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mn = 0; m_done = 0; wexp = 0;
    for (int i = 0; i < 256; i++) ram[i] = 0;
  endtask

  // Drives load_q one word per cycle; ends at a negedge with data_valid low.
  task automatic load();
    foreach (load_q[i]) begin
      bus.data = 8'(load_q[i]);
      bus.data_valid = 1'b1;
      @(negedge clk);
      if (mn < CAP) begin m[mn] = load_q[i]; mn++; end
    end
    bus.data_valid = 1'b0;
  endtask

  // Issues one command at the current negedge; checks busy one cycle later.
  task automatic issue(input int c, input int idx, input int val, input int exp_busy);
    bus.cmd = 3'(c);
    bus.index = 8'(idx);
    bus.value = 8'(val);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    m_apply(c, idx, val);
    @(negedge clk);
    $display("cmd=%0d index=%0d value=%0d busy=%0d", c, idx, val, bus.busy);
    chk("busy_after_cmd", int'(bus.busy), exp_busy);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 300) begin @(negedge clk); k++; end
    if (bus.busy) begin
      total++; bad++;
      $display("FAIL wait_idle timeout busy=%0d required=0", bus.busy);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (!bus.done && k < 300) begin @(negedge clk); k++; end
    chk("done_high", int'(bus.done), 1);
    chk("busy_in_done", int'(bus.busy), 1);
    chk("words_written", wexp, mn);
  endtask

  task automatic check_ram(input string name);
    foreach (expq[i]) chk(name, ram[i], expq[i]);
  endtask

  task automatic load_build();
    do_reset();
    load_q = '{4, 1, 3, 2, 16, 9, 10, 14, 8, 7};
    load();
    issue(0, 0, 0, 1);
    wait_idle();
  endtask

  initial begin
    bus.data_valid = 1'b0; bus.data = '0;
    bus.cmd_valid = 1'b0; bus.cmd = '0;
    bus.index = '0; bus.value = '0;

    // Build then write.
    load_build();
    issue(4, 0, 0, 1);
    wait_done();
    expq = '{16, 14, 10, 8, 7, 9, 3, 2, 4, 1};
    check_ram("build_ram");
    // Commands after done are ignored: no further writes, done held.
    issue(1, 0, 0, 1);
    repeat (5) @(negedge clk);
    chk("done_held", int'(bus.done), 1);
    chk("no_rewrite", wexp, 10);

    // Extract max.
    load_build();
    issue(1, 0, 0, 1);
    wait_idle();
    issue(4, 0, 0, 1);
    wait_done();
    expq = '{14, 8, 10, 4, 7, 9, 3, 2, 1, 0};
    check_ram("extract_ram");

    // Increase value.
    load_build();
    issue(2, 8, 15, 1);
    wait_idle();
    issue(4, 0, 0, 1);
    wait_done();
    expq = '{16, 15, 10, 14, 7, 9, 3, 2, 8, 1};
    check_ram("increase_ram");

    // Insert, then write issued back-to-back as busy falls.
    load_build();
    issue(3, 0, 15, 1);
    wait_idle();
    issue(4, 0, 0, 1);
    wait_done();
    expq = '{16, 15, 10, 8, 14, 9, 3, 2, 4, 1, 7};
    check_ram("insert_ram");

    // No-ops: extract on empty, unknown code, increase out of range.
    do_reset();
    issue(1, 0, 0, 1);
    wait_idle();
    issue(7, 0, 0, 0);
    load_q = '{3, 1, 2};
    load();
    issue(2, 3, 99, 1);
    wait_idle();
    issue(2, 200, 99, 1);
    wait_idle();
    issue(4, 0, 0, 1);
    wait_done();
    expq = '{3, 1, 2, 0};
    check_ram("noop_ram");

    // Write with an empty array: done directly after capture.
    do_reset();
    issue(4, 0, 0, 1);
    chk("empty_write_done", int'(bus.done), 1);
    chk("empty_write_count", wexp, 0);

    // Reset in the middle of a build, then reload and write.
    do_reset();
    load_q = '{4, 1, 3, 2, 16, 9, 10, 14, 8, 7};
    load();
    issue(0, 0, 0, 1);
    @(negedge clk);
    chk("build_in_progress", int'(bus.busy), 1);
    do_reset();
    load_q = '{5, 200, 7};
    load();
    issue(4, 0, 0, 1);
    wait_done();
    expq = '{5, 200, 7, 0};
    check_ram("reset_reload_ram");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
